// File: rtl/bus_resp_pkg.sv
// Shared types for the bus RAM responder: FSM state encoding, op encoding, data width.
package bus_resp_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    StInit  = 3'd0,
    StReady = 3'd1,
    StIdle  = 3'd2,
    StWait  = 3'd3,
    StAck   = 3'd4
  } state_e;

  typedef enum logic {
    OpRead  = 1'b0,
    OpWrite = 1'b1
  } op_e;

endpackage

// File: rtl/bus_resp_ram.sv
// Single-port synchronous RAM with registered read; array is not reset so it maps to block RAM.
module bus_resp_ram
  import bus_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
    rdata_q <= mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram_responder.sv
// Deterministic-latency RAM responder for the we_i/rd_i/ack_o handshake: clears RAM after
// reset, emits one ready ack, then serves one read or write per request.
module bus_ram_responder
  import bus_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              we_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              init_done_o,
  output logic              busy_o,
  output logic [15:0]       state_value_o
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        wait_q, wait_d;
  logic [7:0]        count_q, count_d;
  logic              ack_q, ack_d;
  logic              init_done_q, init_done_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[DATA_W-1:ADDR_W];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    data_d    = data_q;
    wait_d    = wait_q;
    count_d   = count_q;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    unique case (state_q)
      StInit: begin
        if (INIT_CLEAR) begin
          ram_we    = 1'b1;
          ram_addr  = ptr_q;
          ram_wdata = '0;
          ptr_d     = ptr_q + 1'b1;
          if (ptr_q == '1) state_d = StReady;
        end else begin
          state_d = StReady;
        end
      end
      StReady: state_d = StIdle;
      StIdle: begin
        // Read the incoming address now so the word is ready even with zero wait cycles.
        ram_addr = addr_i[ADDR_W-1:0];
        if (we_i || rd_i) begin
          addr_d  = addr_i[ADDR_W-1:0];
          wdata_d = data_i;
          op_d    = we_i ? OpWrite : OpRead;
          wait_d  = WaitInit;
          state_d = (WaitInit == 4'd0) ? StAck : StWait;
        end
      end
      StWait: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= 4'd1) state_d = StAck;
      end
      StAck: begin
        count_d = count_q + 1'b1;
        state_d = StIdle;
        if (op_q == OpWrite) ram_we = 1'b1;
        else                 data_d = ram_rdata;
      end
      default: state_d = StInit;
    endcase
    ack_d       = (state_d == StReady) || (state_d == StAck);
    init_done_d = init_done_q || (state_d == StReady);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StInit;
      op_q        <= OpRead;
      ptr_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
      count_q     <= count_d;
      ack_q       <= ack_d;
      init_done_q <= init_done_d;
    end
  end

  bus_resp_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read data is live from the RAM during the read ack, then held in data_q.
  assign data_o        = (state_q == StAck && op_q == OpRead) ? ram_rdata : data_q;
  assign ack_o         = ack_q;
  assign init_done_o   = init_done_q;
  assign busy_o        = (state_q != StIdle);
  assign state_value_o = {1'b0, state_q, wait_q, count_q};

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench: dut 0 has ADDR_W=4, WAIT_CYCLES=2; dut 1 has ADDR_W=4, WAIT_CYCLES=0.
module tb_bus_ram_responder;

  typedef struct {
    bit          we;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        we_s   [2];
  logic        rd_s   [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s   [2];
  logic [31:0] dout_s [2];
  logic        ack_s  [2];
  logic        done_s [2];
  logic        busy_s [2];
  logic [15:0] dbg_s  [2];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_cnt [2];
  vec_t vecs [8];

  always #5 clk = ~clk;

  bus_ram_responder #(.ADDR_W(4), .WAIT_CYCLES(2), .INIT_CLEAR(1'b1)) u_dut0 (
    .clk           (clk),
    .rstn          (rstn),
    .addr_i        (addr_s[0]),
    .data_i        (wd_s[0]),
    .we_i          (we_s[0]),
    .rd_i          (rd_s[0]),
    .data_o        (dout_s[0]),
    .ack_o         (ack_s[0]),
    .init_done_o   (done_s[0]),
    .busy_o        (busy_s[0]),
    .state_value_o (dbg_s[0])
  );

  bus_ram_responder #(.ADDR_W(4), .WAIT_CYCLES(0), .INIT_CLEAR(1'b1)) u_dut1 (
    .clk           (clk),
    .rstn          (rstn),
    .addr_i        (addr_s[1]),
    .data_i        (wd_s[1]),
    .we_i          (we_s[1]),
    .rd_i          (rd_s[1]),
    .data_o        (dout_s[1]),
    .ack_o         (ack_s[1]),
    .init_done_o   (done_s[1]),
    .busy_o        (busy_s[1]),
    .state_value_o (dbg_s[1])
  );

  initial begin
    ack_cnt[0] = 0;
    ack_cnt[1] = 0;
  end

  always @(negedge clk) begin
    if (ack_s[0] === 1'b1) ack_cnt[0]++;
    if (ack_s[1] === 1'b1) ack_cnt[1]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Counts edges after reset release until each dut shows its ready ack.
  task automatic wait_ready(input string tag);
    int first [2];
    int base  [2];
    first[0] = -1;
    first[1] = -1;
    base[0]  = ack_cnt[0];
    base[1]  = ack_cnt[1];
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ack_s[d] === 1'b1 && first[d] < 0) first[d] = n;
      end
    end
    for (int d = 0; d < 2; d++) begin
      // 16 clear cycles, then the ack appears in the 17th cycle.
      check($sformatf("%s ready edge d%0d", tag, d), first[d], 16);
      check($sformatf("%s ready acks d%0d", tag, d), ack_cnt[d] - base[d], 1);
      check($sformatf("%s init_done d%0d", tag, d), {31'd0, done_s[d]}, 1);
      check($sformatf("%s idle busy d%0d", tag, d), {31'd0, busy_s[d]}, 0);
    end
  endtask

  task automatic do_req(input int d, input bit w, input bit r, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] q);
    @(negedge clk);
    we_s[d]   = w;
    rd_s[d]   = r;
    addr_s[d] = a;
    wd_s[d]   = wd;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_s[d] === 1'b1) begin
        lat = n;
        break;
      end
    end
    q = dout_s[d];
    @(posedge clk);
    #1;
    we_s[d] = 1'b0;
    rd_s[d] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [31:0] q;
    logic [31:0] w;
    logic [3:0]  a;

    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      we_s[d]   = 1'b0;
      rd_s[d]   = 1'b0;
      addr_s[d] = '0;
      wd_s[d]   = '0;
    end

    vecs[0] = '{1'b0, 1'b1, 32'h0000_0007, 32'h0,         32'h0000_0000};
    vecs[1] = '{1'b0, 1'b1, 32'hFFFF_0007, 32'h0,         32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0003, 32'h1234_5678, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,         32'h1234_5678};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0005, 32'hA5A5_A5A5, 32'h1234_5678};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0005, 32'h0,         32'hA5A5_A5A5};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0013, 32'hCAFE_F00D, 32'hA5A5_A5A5};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0,         32'hCAFE_F00D};

    repeat (3) @(negedge clk);
    check("reset data_o", dout_s[0], 32'h0);
    check("reset ack_o", {31'd0, ack_s[0]}, 0);
    check("reset init_done_o", {31'd0, done_s[0]}, 0);
    check("reset busy_o", {31'd0, busy_s[0]}, 1);
    check("reset state_value_o", {16'd0, dbg_s[0]}, 32'h0000);
    rstn = 1'b1;
    wait_ready("por");

    for (int i = 0; i < 8; i++) begin
      do_req(0, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].wdata, lat, q);
      check($sformatf("vec%0d latency", i), lat, 3);
      check($sformatf("vec%0d data_o", i), q, vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("vec%0d no second ack", i), {31'd0, ack_s[0]}, 0);
      check($sformatf("vec%0d idle busy", i), {31'd0, busy_s[0]}, 0);
    end
    check("table req_count", {24'd0, dbg_s[0][7:0]}, 8);
    check("table ack total", ack_cnt[0], 9);

    // Request dropped and address changed after capture: latched values still complete.
    @(negedge clk);
    rd_s[0]   = 1'b1;
    addr_s[0] = 32'h3;
    @(posedge clk);
    #1;
    rd_s[0]   = 1'b0;
    addr_s[0] = 32'h5;
    lat = -1;
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_s[0] === 1'b1) begin
        lat = n;
        break;
      end
    end
    check("dropped req latency", lat, 3);
    check("dropped req data_o", dout_s[0], 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    check("dropped req single ack", ack_cnt[0], 10);

    // Reset during WAIT of a write: the write and its ack are discarded.
    @(negedge clk);
    we_s[0]   = 1'b1;
    addr_s[0] = 32'h2;
    wd_s[0]   = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    check("wait state_value_o", {16'd0, dbg_s[0]}, 32'h3209);
    check("wait busy_o", {31'd0, busy_s[0]}, 1);
    rstn    = 1'b0;
    we_s[0] = 1'b0;
    #1;
    check("midreset data_o", dout_s[0], 32'h0);
    check("midreset ack_o", {31'd0, ack_s[0]}, 0);
    check("midreset init_done_o", {31'd0, done_s[0]}, 0);
    check("midreset busy_o", {31'd0, busy_s[0]}, 1);
    check("midreset state_value_o", {16'd0, dbg_s[0]}, 32'h0000);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    wait_ready("rerun");
    do_req(0, 1'b0, 1'b1, 32'h2, 32'h0, lat, q);
    check("post reset read latency", lat, 3);
    check("post reset read data", q, 32'h0);
    @(negedge clk);
    check("post reset ack total", ack_cnt[0], 12);
    check("post reset req_count", {24'd0, dbg_s[0][7:0]}, 1);

    // Zero-wait dut: alternating write/read pairs with counter data.
    for (int i = 0; i < 50; i++) begin
      a = 4'(i * 5);
      w = 32'h0100_0000 + i;
      do_req(1, 1'b1, 1'b0, {28'd0, a}, w, lat, q);
      check($sformatf("w0 write%0d latency", i), lat, 1);
      do_req(1, 1'b0, 1'b1, {28'd0, a}, 32'h0, lat, q);
      check($sformatf("w0 read%0d latency", i), lat, 1);
      check($sformatf("w0 read%0d data", i), q, w);
    end
    @(negedge clk);
    check("w0 ack total", ack_cnt[1], 102);
    check("w0 req_count", {24'd0, dbg_s[1][7:0]}, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
